// File: rtl/ahb_write_master.sv
// ahb_write_master -- AHB-Lite write initiator for the three-register write
// slave (payload_0, payload_1, data_size). One accepted command becomes a
// burst of NUM_BEATS write beats (NONSEQ then SEQ), beat k addressing
// register k. Wait states and the two-cycle ERROR response are honoured, and
// completion is reported with a one-cycle done or error pulse.
//
// Optional feature: define AHB_WRITE_TIMEOUT_EN to add a wait-state watchdog
// that aborts the command with an error after TIMEOUT_CYCLES consecutive
// stalled cycles. Without the macro the master waits for hready indefinitely.
module ahb_write_master #(
   parameter int DATA_W         = 8,
   parameter int NUM_BEATS      = 3,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic              hclk,
   input  logic              hreset_n,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [DATA_W-1:0] cmd_payload_0,
   input  logic [DATA_W-1:0] cmd_payload_1,
   input  logic [4:0]        cmd_data_size,
   input  logic              hready,
   input  logic              hresp,
   output logic              hsel_x,
   output logic              hwrite,
   output logic [1:0]        htrans,
   output logic [1:0]        write_select,
   output logic [DATA_W-1:0] hwdata,
   output logic              done,
   output logic              error
);

   localparam logic [1:0] HTRANS_IDLE   = 2'd0;
   localparam logic [1:0] HTRANS_NONSEQ = 2'd2;
   localparam logic [1:0] HTRANS_SEQ    = 2'd3;
   localparam logic [1:0] LAST_BEAT     = 2'(NUM_BEATS - 1);

   // Parameter sanity: beat index is two bits and data_size must fit hwdata.
   generate
      if (NUM_BEATS < 1 || NUM_BEATS > 3) begin : g_bad_beats
         $error("ahb_write_master: NUM_BEATS must be 1..3");
      end
      if (DATA_W < 5) begin : g_bad_width
         $error("ahb_write_master: DATA_W must be at least 5");
      end
      if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
         $error("ahb_write_master: TIMEOUT_CYCLES must be at least 1");
      end
   endgenerate

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      XFER   = 2'd1,
      CANCEL = 2'd2,
      RESP   = 2'd3
   } state_t;

   state_t            state;
   logic [1:0]        beat;
   logic [DATA_W-1:0] payload_0_q;
   logic [DATA_W-1:0] payload_1_q;
   logic [4:0]        size_q;

`ifdef AHB_WRITE_TIMEOUT_EN
   localparam int                WAIT_W    = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);
   logic [WAIT_W-1:0] wait_cnt;
`endif

   // Data driven on hwdata for a given beat index; data_size is zero-extended.
   function automatic logic [DATA_W-1:0] beat_data(
      input logic [1:0]        idx,
      input logic [DATA_W-1:0] p0,
      input logic [DATA_W-1:0] p1,
      input logic [4:0]        sz
   );
      case (idx)
         2'd0:    beat_data = p0;
         2'd1:    beat_data = p1;
         default: beat_data = DATA_W'(sz);
      endcase
   endfunction

   // Command FSM; every output is a register updated alongside the state.
   always_ff @(posedge hclk or negedge hreset_n) begin
      if (!hreset_n) begin
         state        <= IDLE;
         beat         <= 2'd0;
         payload_0_q  <= '0;
         payload_1_q  <= '0;
         size_q       <= '0;
         cmd_ready    <= 1'b0;
         hsel_x       <= 1'b0;
         hwrite       <= 1'b0;
         htrans       <= HTRANS_IDLE;
         write_select <= 2'd0;
         hwdata       <= '0;
         done         <= 1'b0;
         error        <= 1'b0;
`ifdef AHB_WRITE_TIMEOUT_EN
         wait_cnt     <= '0;
`endif
      end else begin
`ifdef AHB_WRITE_TIMEOUT_EN
         // Cleared on every cycle that does not extend a stall.
         wait_cnt <= '0;
`endif
         case (state)
            IDLE: begin
               done  <= 1'b0;
               error <= 1'b0;
               if (cmd_valid && cmd_ready) begin
                  // Latch the whole command; the first beat goes out next cycle.
                  payload_0_q  <= cmd_payload_0;
                  payload_1_q  <= cmd_payload_1;
                  size_q       <= cmd_data_size;
                  beat         <= 2'd0;
                  state        <= XFER;
                  cmd_ready    <= 1'b0;
                  hsel_x       <= 1'b1;
                  hwrite       <= 1'b1;
                  htrans       <= HTRANS_NONSEQ;
                  write_select <= 2'd0;
                  hwdata       <= cmd_payload_0;
               end else begin
                  cmd_ready <= 1'b1;
               end
            end

            XFER: begin
               if (hresp) begin
                  // First ERROR cycle seen: drop remaining beats, idle the bus.
                  state        <= CANCEL;
                  hsel_x       <= 1'b1;
                  hwrite       <= 1'b0;
                  htrans       <= HTRANS_IDLE;
                  write_select <= 2'd0;
                  hwdata       <= '0;
               end else if (hready) begin
                  if (beat < LAST_BEAT) begin
                     // Next beat back-to-back, always SEQ after the first.
                     beat         <= beat + 2'd1;
                     htrans       <= HTRANS_SEQ;
                     write_select <= beat + 2'd1;
                     hwdata       <= beat_data(beat + 2'd1, payload_0_q,
                                               payload_1_q, size_q);
                  end else begin
                     state        <= RESP;
                     done         <= 1'b1;
                     hsel_x       <= 1'b0;
                     hwrite       <= 1'b0;
                     htrans       <= HTRANS_IDLE;
                     write_select <= 2'd0;
                     hwdata       <= '0;
                  end
`ifdef AHB_WRITE_TIMEOUT_EN
               end else if (wait_cnt == WAIT_LAST) begin
                  // Slave stalled too long: abort straight to an error report.
                  state        <= RESP;
                  error        <= 1'b1;
                  hsel_x       <= 1'b0;
                  hwrite       <= 1'b0;
                  htrans       <= HTRANS_IDLE;
                  write_select <= 2'd0;
                  hwdata       <= '0;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
`endif
               end
               // Otherwise a wait state: all bus outputs simply hold.
            end

            CANCEL: begin
               if (hready) begin
                  state  <= RESP;
                  error  <= 1'b1;
                  hsel_x <= 1'b0;
`ifdef AHB_WRITE_TIMEOUT_EN
               end else if (wait_cnt == WAIT_LAST) begin
                  state  <= RESP;
                  error  <= 1'b1;
                  hsel_x <= 1'b0;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
`endif
               end
            end

            RESP: begin
               // Single status cycle, then ready for the next command.
               done      <= 1'b0;
               error     <= 1'b0;
               cmd_ready <= 1'b1;
               state     <= IDLE;
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ahb_write_master.sv
// Testbench for ahb_write_master: table-driven per-cycle vectors for the
// three-beat instance, plus hand-written sequences for reset mid-burst, the
// single-beat instance with a held cmd_valid, and (when compiled in) timeout.
module tb_ahb_write_master;

   logic       hclk = 1'b0;
   logic       hreset_n = 1'b0;
   logic       cmd_valid = 1'b0;
   logic       cmd_valid1 = 1'b0;
   logic [7:0] cmd_payload_0 = '0;
   logic [7:0] cmd_payload_1 = '0;
   logic [4:0] cmd_data_size = '0;
   logic       hready = 1'b1;
   logic       hresp = 1'b0;

   logic       cmd_ready, hsel_x, hwrite, done, error;
   logic [1:0] htrans, write_select;
   logic [7:0] hwdata;

   logic       cmd_ready1, hsel_x1, hwrite1, done1, error1;
   logic [1:0] htrans1, write_select1;
   logic [7:0] hwdata1;

   int tests = 0;
   int fails = 0;

   always #5 hclk = ~hclk;

   ahb_write_master #(.DATA_W(8), .NUM_BEATS(3), .TIMEOUT_CYCLES(4)) dut (
      .hclk(hclk), .hreset_n(hreset_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_payload_0(cmd_payload_0), .cmd_payload_1(cmd_payload_1),
      .cmd_data_size(cmd_data_size),
      .hready(hready), .hresp(hresp),
      .hsel_x(hsel_x), .hwrite(hwrite), .htrans(htrans),
      .write_select(write_select), .hwdata(hwdata),
      .done(done), .error(error)
   );

   ahb_write_master #(.DATA_W(8), .NUM_BEATS(1), .TIMEOUT_CYCLES(4)) dut1 (
      .hclk(hclk), .hreset_n(hreset_n),
      .cmd_valid(cmd_valid1), .cmd_ready(cmd_ready1),
      .cmd_payload_0(cmd_payload_0), .cmd_payload_1(cmd_payload_1),
      .cmd_data_size(cmd_data_size),
      .hready(hready), .hresp(hresp),
      .hsel_x(hsel_x1), .hwrite(hwrite1), .htrans(htrans1),
      .write_select(write_select1), .hwdata(hwdata1),
      .done(done1), .error(error1)
   );

   typedef struct {
      logic       valid;
      logic [7:0] p0;
      logic [7:0] p1;
      logic [4:0] ds;
      logic       hr;
      logic       rsp;
      logic       rdy;
      logic       sel;
      logic       wr;
      logic [1:0] ht;
      logic [1:0] ws;
      logic [7:0] wd;
      logic       dn;
      logic       er;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(
      input logic valid, input logic [7:0] p0, input logic [7:0] p1,
      input logic [4:0] ds, input logic hr, input logic rsp,
      input logic rdy, input logic sel, input logic wr, input logic [1:0] ht,
      input logic [1:0] ws, input logic [7:0] wd, input logic dn, input logic er
   );
      vec_t v;
      v.valid = valid; v.p0 = p0; v.p1 = p1; v.ds = ds; v.hr = hr; v.rsp = rsp;
      v.rdy = rdy; v.sel = sel; v.wr = wr; v.ht = ht; v.ws = ws; v.wd = wd;
      v.dn = dn; v.er = er;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Hard stop guard in case the bench itself loses track of time.
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // Expected outputs are those visible just after the clock edge.
      // Basic three-beat burst; inputs changed after acceptance.
      vecs.push_back(mk(1, 8'hA5, 8'h3C, 5'd17, 1, 0,  0, 1, 1, 2, 0, 8'hA5, 0, 0));
      vecs.push_back(mk(0, 8'h00, 8'hFF, 5'd31, 1, 0,  0, 1, 1, 3, 1, 8'h3C, 0, 0));
      vecs.push_back(mk(0, 8'h00, 8'hFF, 5'd31, 1, 0,  0, 1, 1, 3, 2, 8'h11, 0, 0));
      vecs.push_back(mk(0, 8'h00, 8'hFF, 5'd31, 1, 0,  0, 0, 0, 0, 0, 8'h00, 1, 0));
      vecs.push_back(mk(0, 8'h00, 8'hFF, 5'd31, 1, 0,  1, 0, 0, 0, 0, 8'h00, 0, 0));
      // Two wait states on beat 1.
      vecs.push_back(mk(1, 8'h5A, 8'hC3, 5'd3,  1, 0,  0, 1, 1, 2, 0, 8'h5A, 0, 0));
      vecs.push_back(mk(0, 8'h5A, 8'hC3, 5'd3,  1, 0,  0, 1, 1, 3, 1, 8'hC3, 0, 0));
      vecs.push_back(mk(0, 8'h5A, 8'hC3, 5'd3,  0, 0,  0, 1, 1, 3, 1, 8'hC3, 0, 0));
      vecs.push_back(mk(0, 8'h5A, 8'hC3, 5'd3,  0, 0,  0, 1, 1, 3, 1, 8'hC3, 0, 0));
      vecs.push_back(mk(0, 8'h5A, 8'hC3, 5'd3,  1, 0,  0, 1, 1, 3, 2, 8'h03, 0, 0));
      vecs.push_back(mk(0, 8'h5A, 8'hC3, 5'd3,  1, 0,  0, 0, 0, 0, 0, 8'h00, 1, 0));
      vecs.push_back(mk(0, 8'h5A, 8'hC3, 5'd3,  1, 0,  1, 0, 0, 0, 0, 8'h00, 0, 0));
      // ERROR on beat 0: first cycle with hready low, second with hready high.
      vecs.push_back(mk(1, 8'h11, 8'h22, 5'd4,  1, 0,  0, 1, 1, 2, 0, 8'h11, 0, 0));
      vecs.push_back(mk(0, 8'h11, 8'h22, 5'd4,  0, 1,  0, 1, 0, 0, 0, 8'h00, 0, 0));
      vecs.push_back(mk(0, 8'h11, 8'h22, 5'd4,  1, 1,  0, 0, 0, 0, 0, 8'h00, 0, 1));
      vecs.push_back(mk(0, 8'h11, 8'h22, 5'd4,  1, 0,  1, 0, 0, 0, 0, 8'h00, 0, 0));
      // ERROR on beat 1 seen with hready high, CANCEL then stalls one cycle.
      vecs.push_back(mk(1, 8'h77, 8'h88, 5'd9,  1, 0,  0, 1, 1, 2, 0, 8'h77, 0, 0));
      vecs.push_back(mk(0, 8'h77, 8'h88, 5'd9,  1, 0,  0, 1, 1, 3, 1, 8'h88, 0, 0));
      vecs.push_back(mk(0, 8'h77, 8'h88, 5'd9,  1, 1,  0, 1, 0, 0, 0, 8'h00, 0, 0));
      vecs.push_back(mk(0, 8'h77, 8'h88, 5'd9,  0, 0,  0, 1, 0, 0, 0, 8'h00, 0, 0));
      vecs.push_back(mk(0, 8'h77, 8'h88, 5'd9,  1, 0,  0, 0, 0, 0, 0, 8'h00, 0, 1));
      vecs.push_back(mk(0, 8'h77, 8'h88, 5'd9,  1, 0,  1, 0, 0, 0, 0, 8'h00, 0, 0));

      // Reset state.
      #12;
      chk("reset.cmd_ready", cmd_ready, 0);
      chk("reset.hsel_x", hsel_x, 0);
      chk("reset.hwrite", hwrite, 0);
      chk("reset.htrans", htrans, 0);
      chk("reset.hwdata", hwdata, 0);
      chk("reset.done_error", {done, error}, 0);
      @(negedge hclk);
      hreset_n = 1'b1;
      @(posedge hclk); #1;
      chk("post_reset.cmd_ready", cmd_ready, 1);

      // Table-driven vectors.
      for (int i = 0; i < vecs.size(); i++) begin
         @(negedge hclk);
         cmd_valid     = vecs[i].valid;
         cmd_payload_0 = vecs[i].p0;
         cmd_payload_1 = vecs[i].p1;
         cmd_data_size = vecs[i].ds;
         hready        = vecs[i].hr;
         hresp         = vecs[i].rsp;
         @(posedge hclk); #1;
         chk($sformatf("v%0d.cmd_ready", i), cmd_ready, vecs[i].rdy);
         chk($sformatf("v%0d.hsel_x", i), hsel_x, vecs[i].sel);
         chk($sformatf("v%0d.hwrite", i), hwrite, vecs[i].wr);
         chk($sformatf("v%0d.htrans", i), htrans, vecs[i].ht);
         chk($sformatf("v%0d.write_select", i), write_select, vecs[i].ws);
         chk($sformatf("v%0d.hwdata", i), hwdata, vecs[i].wd);
         chk($sformatf("v%0d.done", i), done, vecs[i].dn);
         chk($sformatf("v%0d.error", i), error, vecs[i].er);
      end

      // Reset mid-burst: asynchronous clear during beat 1, no status pulse after.
      @(negedge hclk);
      cmd_valid = 1'b1; cmd_payload_0 = 8'hE1; cmd_payload_1 = 8'hE2;
      cmd_data_size = 5'd5; hready = 1'b1; hresp = 1'b0;
      @(negedge hclk);
      cmd_valid = 1'b0;
      @(posedge hclk); #1;
      chk("midrst.pre_write_select", write_select, 1);
      #2;
      hreset_n = 1'b0;
      #1;
      chk("midrst.async_bus", {hsel_x, hwrite, htrans, write_select, hwdata}, 0);
      chk("midrst.async_status", {cmd_ready, done, error}, 0);
      @(negedge hclk);
      hreset_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(posedge hclk); #1;
         chk($sformatf("midrst.c%0d.done_error", i), {done, error}, 0);
         chk($sformatf("midrst.c%0d.htrans", i), htrans, 0);
      end
      chk("midrst.cmd_ready", cmd_ready, 1);

      // Single-beat instance with cmd_valid held high.
      begin
         logic [1:0] exp_ht[6] = '{2, 0, 0, 2, 0, 0};
         logic       exp_dn[6] = '{0, 1, 0, 0, 1, 0};
         logic       exp_rd[6] = '{0, 0, 1, 0, 0, 1};
         @(negedge hclk);
         cmd_valid1 = 1'b1; cmd_payload_0 = 8'h4D; hready = 1'b1; hresp = 1'b0;
         for (int i = 0; i < 6; i++) begin
            @(posedge hclk); #1;
            chk($sformatf("nb1.c%0d.htrans", i), htrans1, exp_ht[i]);
            chk($sformatf("nb1.c%0d.done", i), done1, exp_dn[i]);
            chk($sformatf("nb1.c%0d.cmd_ready", i), cmd_ready1, exp_rd[i]);
            chk($sformatf("nb1.c%0d.write_select", i), write_select1, 0);
            if (exp_ht[i] == 2'd2)
               chk($sformatf("nb1.c%0d.hwdata", i), hwdata1, 8'h4D);
         end
         @(negedge hclk);
         cmd_valid1 = 1'b0;
      end

`ifdef AHB_WRITE_TIMEOUT_EN
      // Watchdog: beat 0 stalls with hready low until the timeout fires.
      @(negedge hclk);
      cmd_valid = 1'b1; cmd_payload_0 = 8'h99; hready = 1'b1; hresp = 1'b0;
      @(posedge hclk); #1;
      chk("tmo.first_beat", htrans, 2);
      @(negedge hclk);
      cmd_valid = 1'b0; hready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(posedge hclk); #1;
         chk($sformatf("tmo.c%0d.htrans", i), htrans, (i < 3) ? 2 : 0);
         chk($sformatf("tmo.c%0d.error", i), error, (i == 3) ? 1 : 0);
         chk($sformatf("tmo.c%0d.done", i), done, 0);
      end
      @(negedge hclk);
      hready = 1'b1;
      @(posedge hclk); #1;
      chk("tmo.back_to_idle", {cmd_ready, error}, 2'b10);
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/ahb_write_master.md
Name: ahb_write_master

Overview:
- Upstream AHB-Lite write initiator for the 3-register write slave (payload_0, payload_1, data_size).
- Accepts one command carrying two payload bytes and a 5-bit size. Issues it as a burst of write beats (NONSEQ, then SEQ), one register per beat, with write_select equal to the beat index.
- Honours hready wait states and the two-cycle hresp ERROR response.
- Reports completion or error to the local requester with a one-cycle pulse.

Parameters:
- DATA_W, 8: hwdata and payload width.
- NUM_BEATS, 3: beats per command, legal range 1..3. Beat k writes register k (0=payload_0, 1=payload_1, 2=data_size).
- TIMEOUT_CYCLES, 16: wait-state limit. Used only when the optional feature is compiled in.

Ports:
- hclk  in  1  clock; all logic on the rising edge.
- hreset_n  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high only in IDLE.
- cmd_payload_0  in  DATA_W  data for beat 0.
- cmd_payload_1  in  DATA_W  data for beat 1.
- cmd_data_size  in  5  data for beat 2; zero-extended onto hwdata.
- hready  in  1  bus ready (slave hready_out via the interconnect).
- hresp  in  1  bus response; 0=OKAY, 1=ERROR.
- hsel_x  out  1  slave select; high in XFER.
- hwrite  out  1  high in XFER.
- htrans  out  2  0=IDLE, 2=NONSEQ, 3=SEQ.
- write_select  out  2  current beat index.
- hwdata  out  DATA_W  current beat data.
- done  out  1  one-cycle pulse; command completed OKAY.
- error  out  1  one-cycle pulse; command aborted.

Behaviour:
- Reset (async, hreset_n low):
  - State goes to IDLE; beat counter = 0; command registers = 0.
  - All outputs 0; htrans = IDLE.
  - Takes effect immediately, even mid-burst. The in-flight command is discarded with no done and no error pulse.
- All outputs are registered.
- FSM states: IDLE, XFER, CANCEL, RESP.
- IDLE:
  - cmd_ready = 1.
  - On cmd_valid, capture all three command fields, set beat = 0, go to XFER.
  - The first beat is on the bus the cycle after acceptance (1-cycle latency).
- XFER:
  - hsel_x = 1, hwrite = 1, write_select = beat.
  - htrans = NONSEQ for beat 0, SEQ for later beats.
  - hwdata per beat: beat 0 = payload_0, beat 1 = payload_1, beat 2 = {zeros, data_size}.
  - Edge with hready = 1 and hresp = 0: the beat is done.
    - If beat < NUM_BEATS-1: beat increments and the next beat is driven the following cycle (back-to-back, no idle gap).
    - Otherwise: go to RESP with status OKAY.
  - Edge with hready = 0 and hresp = 0: wait state; all bus outputs held stable.
  - Edge with hresp = 1 (either hready value): go to CANCEL.
- CANCEL (second cycle of the ERROR response):
  - htrans = IDLE, hsel_x = 1, hwrite = 0.
  - Remaining beats are dropped.
  - Stay until hready = 1, then go to RESP with status ERROR.
- RESP:
  - Exactly one cycle; htrans = IDLE, hsel_x = 0.
  - Pulse done (status OKAY) or error (status ERROR).
  - Return to IDLE. cmd_ready is 0 during RESP, so a new command can be accepted no sooner than 2 cycles after the last beat.
- Command inputs are sampled only at acceptance. Later changes to them do not affect the burst in progress.
- Beat counter is 2 bits and never exceeds NUM_BEATS-1; there is no wrap past 3.
- done and error are never high in the same cycle.

Optional Feature:
- Macro: AHB_WRITE_TIMEOUT_EN.
- Compiled in:
  - A wait counter increments on each XFER or CANCEL cycle with hready = 0.
  - It clears on hready = 1 and on a state change.
  - When it reaches TIMEOUT_CYCLES, the FSM goes directly to RESP with status ERROR and bus outputs return to IDLE.
- Compiled out: no counter exists and the master waits indefinitely for hready.

Test Plan:
- Basic burst, no wait states. Reset, then cmd_payload_0=8'hA5, cmd_payload_1=8'h3C, cmd_data_size=5'd17, cmd_valid for one cycle, hready=1 throughout.
  -> htrans 2,3,3 on consecutive cycles; write_select 0,1,2; hwdata A5,3C,11. Then done pulses once; slave ends with payload_0=A5, payload_1=3C, data_size=17.
- Wait states. hready=0 for 2 cycles during beat 1.
  -> write_select=1 and hwdata=3C held for 3 cycles; burst completes; done 2 cycles later than the no-wait case.
- ERROR response. hresp=1 with hready=0 on beat 0, then hresp=1 with hready=1.
  -> htrans=IDLE in the next cycle; beats 1 and 2 are never driven; error pulses once; done stays 0.
- Reset mid-burst. Assert hreset_n=0 during beat 1.
  -> All outputs 0 asynchronously; after release cmd_ready=1 and neither done nor error pulses.
- NUM_BEATS=1 and back-to-back commands.
  -> Each command produces a single NONSEQ beat with write_select=0. A cmd_valid held high is accepted again 2 cycles after that beat.
- Timeout, with AHB_WRITE_TIMEOUT_EN compiled in and TIMEOUT_CYCLES=4. Hold hready=0.
  -> error pulses after 4 stalled cycles; htrans returns to 0.
